fta_io_responder32: RTL

Device-end responder for the 32-bit FTA I/O channel: accepts `fta_cmd_request32_t` transactions from the I/O bridge's master port, filters them by address window, queues them, sequences each one onto a simple local register-bus handshake, and returns a `fta_cmd_response32_t` with the transaction tags echoed. It is the piece each low-speed peripheral instantiates so it can sit on the bridge's channel and feed one entry of the bridge's response-buffer array.

---
 rtl/fta_bus_pkg.sv | 59 +++++
 rtl/fta_cmd_fifo.sv | 55 +++++
 rtl/fta_io_responder32.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fta_bus_pkg.sv
// Shared FTA I/O channel types and responder constants.
package fta_bus_pkg;

  typedef logic [3:0] fta_cid_t;
  typedef logic [7:0] fta_tid_t;

  typedef struct packed {
    fta_cid_t    cid;
    fta_tid_t    tid;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] padr;
    logic [31:0] dat;
  } fta_cmd_request32_t;

  typedef struct packed {
    fta_cid_t    cid;
    fta_tid_t    tid;
    logic        stall;
    logic        next;
    logic        ack;
    logic        rty;
    logic        err;
    logic [3:0]  pri;
    logic [31:0] adr;
    logic [31:0] dat;
  } fta_cmd_response32_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] padr;
    logic [31:0] dat;
    fta_cid_t    cid;
    fta_tid_t    tid;
  } fta_cmd_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } fta_rsp_state_t;

  localparam logic [31:0] FTA_TO_DATA = 32'hDEADDEAD;

  function automatic fta_cmd_entry_t fta_req_to_entry(input fta_cmd_request32_t r);
    fta_cmd_entry_t e;
    e.we   = r.we;
    e.sel  = r.sel;
    e.padr = r.padr;
    e.dat  = r.dat;
    e.cid  = r.cid;
    e.tid  = r.tid;
    return e;
  endfunction

endpackage

// File: rtl/fta_cmd_fifo.sv
// Synchronous command FIFO; push ignored when full, pop ignored when empty.
module fta_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_LVL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fta_io_responder32.sv
// Device-end FTA responder: window filter, command queue, local bus sequencer.
module fta_io_responder32
  import fta_bus_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'hFEE00000,
  parameter logic [31:0] MASK      = 32'hFFFF0000,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TO_CYCLES = 255,
  parameter logic [3:0]  PRI       = 4'd7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  fta_cmd_request32_t  req,
  output fta_cmd_response32_t resp,
  output logic                dev_cs_o,
  output logic                dev_we_o,
  output logic [31:0]         dev_adr_o,
  output logic [3:0]          dev_sel_o,
  output logic [31:0]         dev_dat_o,
  input  logic                dev_ack_i,
  input  logic [31:0]         dev_dat_i
);

  localparam int unsigned     CNTW        = $clog2(DEPTH) + 1;
  localparam logic [7:0]      TO_LIMIT    = 8'(TO_CYCLES);
  localparam logic [CNTW-1:0] STALL_LEVEL = CNTW'(DEPTH - 1);

  fta_rsp_state_t      state_q, state_d;
  fta_cmd_entry_t      cur_q;
  fta_cmd_entry_t      head;
  fta_cmd_entry_t      req_entry;
  logic [7:0]          cnt_q;
  logic                accept;
  logic                push;
  logic                pop;
  logic                reject;
  logic                start;
  logic                done;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNTW-1:0]     fifo_count;
  logic [CNTW-1:0]     count_nxt;
  fta_cmd_response32_t resp_q, rsp_d;
  fta_cmd_response32_t cmp_rsp, rty_rsp;
  fta_cmd_response32_t hold_q;
  logic                hold_v_q;

  assign req_entry  = fta_req_to_entry(req);
  assign accept     = req.cyc & req.stb & ((req.padr & MASK) == BASE);
  assign push       = accept & ~fifo_full;
  assign reject     = accept & fifo_full;
  assign done       = (state_q == ACCESS) & (dev_ack_i | (cnt_q == TO_LIMIT));
  assign count_nxt  = fifo_count + CNTW'(push) - CNTW'(pop);

  // The in-flight command keeps its FIFO slot until it completes, so the
  // occupancy seen by full/stall includes it; an empty FIFO is bypassed
  // straight into the current register for two-cycle latency.
  fta_cmd_fifo #(
    .WIDTH ($bits(fta_cmd_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (req_entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cur_q <= fifo_empty ? req_entry : head;
        cnt_q <= '0;
      end else if ((state_q == ACCESS) && !done) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // RESP is held while a retry pre-empts the pending completion.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty || push) begin
          start   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (done) begin
          pop     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!(hold_v_q && reject)) begin
          if (!fifo_empty || push) begin
            start   = 1'b1;
            state_d = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmp_rsp     = '0;
    cmp_rsp.cid = cur_q.cid;
    cmp_rsp.tid = cur_q.tid;
    cmp_rsp.adr = cur_q.padr;
    cmp_rsp.pri = PRI;
    if (dev_ack_i) begin
      cmp_rsp.ack = 1'b1;
      cmp_rsp.dat = cur_q.we ? '0 : dev_dat_i;
    end else begin
      cmp_rsp.err = 1'b1;
      cmp_rsp.dat = FTA_TO_DATA;
    end

    rty_rsp     = '0;
    rty_rsp.cid = req.cid;
    rty_rsp.tid = req.tid;
    rty_rsp.adr = req.padr;
    rty_rsp.pri = PRI;
    rty_rsp.rty = 1'b1;

    rsp_d     = resp_q;
    rsp_d.ack = 1'b0;
    rsp_d.rty = 1'b0;
    rsp_d.err = 1'b0;
    if (reject)        rsp_d = rty_rsp;
    else if (hold_v_q) rsp_d = hold_q;
    else if (done)     rsp_d = cmp_rsp;
    rsp_d.stall = (count_nxt >= STALL_LEVEL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q     <= '0;
      resp_q.pri <= PRI;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
    end else begin
      resp_q <= rsp_d;
      if (reject && done) begin
        hold_q   <= cmp_rsp;
        hold_v_q <= 1'b1;
      end else if (!reject) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  assign resp      = resp_q;
  assign dev_cs_o  = (state_q == ACCESS);
  assign dev_we_o  = dev_cs_o & cur_q.we;
  assign dev_sel_o = dev_cs_o ? cur_q.sel  : '0;
  assign dev_adr_o = dev_cs_o ? cur_q.padr : '0;
  assign dev_dat_o = dev_cs_o ? cur_q.dat  : '0;

endmodule
